// File: rtl/gray_ptr_sync.sv
// Multi-stage synchronizer for Gray-coded FIFO pointers. It also provides a registered binary
// decode, an update strobe, a warm-up valid flag and a sticky multi-bit-change error flag.
module gray_ptr_sync #(
    parameter int unsigned          PTR_WIDTH = 7,
    parameter int unsigned          STAGES    = 2,
    parameter logic [PTR_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PTR_WIDTH-1:0] gray_in,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] sync_gray,
    output logic [PTR_WIDTH-1:0] sync_bin,
    output logic                 ptr_upd,
    output logic                 sync_vld,
    output logic                 gray_err
);

    // Elaboration-time legality checks.
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be in 2..4");
    end
    if (PTR_WIDTH < 2) begin : g_bad_width
        $error("gray_ptr_sync: PTR_WIDTH must be >= 2");
    end

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = int'(PTR_WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [PTR_WIDTH-1:0] ResetBin = gray2bin(RESET_VAL);
    // The counter saturates at STAGES+1. It is 2 bits wide for STAGES=2 and wider for deeper chains.
    localparam int unsigned          CntMax   = STAGES + 1;
    localparam int unsigned          CntW     = $clog2(CntMax + 1);
    localparam logic [CntW-1:0]      CntMaxV  = CntW'(CntMax);

    logic [STAGES-1:0][PTR_WIDTH-1:0] stage_q, stage_d;
    logic [PTR_WIDTH-1:0]             sync_bin_q, sync_bin_d;
    logic [PTR_WIDTH-1:0]             prev_gray_q, prev_gray_d;
    logic                             ptr_upd_q, ptr_upd_d;
    logic                             gray_err_q, gray_err_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [PTR_WIDTH-1:0]             diff;
    logic                             multi_bit;

    assign sync_gray = stage_q[STAGES-1];
    assign sync_bin  = sync_bin_q;
    assign ptr_upd   = ptr_upd_q;
    assign gray_err  = gray_err_q;
    assign sync_vld  = (cnt_q == CntMaxV);

    // More than one set bit in the difference means more than one bit changed (x & (x-1) != 0).
    assign diff      = sync_gray ^ prev_gray_q;
    assign multi_bit = (diff & (diff - PTR_WIDTH'(1))) != '0;

    // Next state: a plain shift chain, then decode, update strobe, warm-up and integrity check.
    always_comb begin
        stage_d     = {stage_q[STAGES-2:0], gray_in};
        sync_bin_d  = gray2bin(sync_gray);
        prev_gray_d = sync_gray;
        ptr_upd_d   = sync_vld && (sync_bin_d != sync_bin_q);
        cnt_d       = cnt_q;
        if (cnt_q != CntMaxV) begin
            cnt_d = cnt_q + CntW'(1);
        end
        // A new error takes priority over a clear on the same edge.
        gray_err_d = gray_err_q;
        if (err_clr) begin
            gray_err_d = 1'b0;
        end
        if (sync_vld && multi_bit) begin
            gray_err_d = 1'b1;
        end
    end

    // State registers. Reset discards in-flight samples and restarts warm-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q     <= {STAGES{RESET_VAL}};
            sync_bin_q  <= ResetBin;
            prev_gray_q <= RESET_VAL;
            ptr_upd_q   <= 1'b0;
            gray_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            stage_q     <= stage_d;
            sync_bin_q  <= sync_bin_d;
            prev_gray_q <= prev_gray_d;
            ptr_upd_q   <= ptr_upd_d;
            gray_err_q  <= gray_err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync. It drives a STAGES=2 instance and a STAGES=3 instance
// from the same inputs.
module tb_gray_ptr_sync;

    localparam int unsigned W = 7;

    logic         clk;
    logic         rst;
    logic [W-1:0] gray_in;
    logic         err_clr;

    logic [W-1:0] sync_gray2, sync_bin2;
    logic         ptr_upd2, sync_vld2, gray_err2;
    logic [W-1:0] sync_gray3, sync_bin3;
    logic         ptr_upd3, sync_vld3, gray_err3;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    gray_ptr_sync #(.PTR_WIDTH(W), .STAGES(2), .RESET_VAL('0)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .sync_gray(sync_gray2),
        .sync_bin (sync_bin2),
        .ptr_upd  (ptr_upd2),
        .sync_vld (sync_vld2),
        .gray_err (gray_err2)
    );

    gray_ptr_sync #(.PTR_WIDTH(W), .STAGES(3), .RESET_VAL('0)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .sync_gray(sync_gray3),
        .sync_bin (sync_bin3),
        .ptr_upd  (ptr_upd3),
        .sync_vld (sync_vld3),
        .gray_err (gray_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference decode as an XOR of all right shifts.
    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int k = 1; k < int'(W); k++) b = b ^ (g >> k);
        return b;
    endfunction

    // Advances one rising edge. Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; gray_in = 7'h55; err_clr = 1'b0;
        step(); step();
        n_cmp += 5;
        if (sync_gray2 !== 7'h00) begin n_err++; $display("FAIL rst_sync_gray got %h want 00", sync_gray2); end
        if (sync_bin2 !== 7'h00)  begin n_err++; $display("FAIL rst_sync_bin got %h want 00", sync_bin2); end
        if (ptr_upd2 !== 1'b0)    begin n_err++; $display("FAIL rst_ptr_upd got %b want 0", ptr_upd2); end
        if (sync_vld2 !== 1'b0)   begin n_err++; $display("FAIL rst_sync_vld got %b want 0", sync_vld2); end
        if (gray_err2 !== 1'b0)   begin n_err++; $display("FAIL rst_gray_err got %b want 0", gray_err2); end
        rst = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (ptr_upd2 || ptr_upd3) pulses++;
            n_cmp++;
            if (sync_vld2 !== (e >= 3)) begin
                n_err++; $display("FAIL warmup_vld2 edge %0d got %b want %b", e, sync_vld2, e >= 3);
            end
            n_cmp++;
            if (sync_vld3 !== (e >= 4)) begin
                n_err++; $display("FAIL warmup_vld3 edge %0d got %b want %b", e, sync_vld3, e >= 4);
            end
        end
        n_cmp += 3;
        if (sync_bin2 !== ref_g2b(7'h55)) begin
            n_err++; $display("FAIL warmup_bin got %h want %h", sync_bin2, ref_g2b(7'h55));
        end
        if (pulses != 0) begin n_err++; $display("FAIL warmup_no_upd got %0d pulses want 0", pulses); end
        if (gray_err2 !== 1'b0) begin n_err++; $display("FAIL warmup_err got %b want 0", gray_err2); end
    endtask

    task automatic test_latency();
        rst = 1'b1; gray_in = 7'h00;
        step();
        rst = 1'b0;
        for (int e = 0; e < 6; e++) step();
        gray_in = 7'h01;
        for (int e = 1; e <= 5; e++) begin
            step();
            n_cmp++;
            if (sync_gray3 !== ((e >= 3) ? 7'h01 : 7'h00)) begin
                n_err++; $display("FAIL lat_gray edge %0d got %h want %h", e, sync_gray3, e >= 3);
            end
            n_cmp++;
            if (sync_bin3 !== ((e >= 4) ? 7'h01 : 7'h00)) begin
                n_err++; $display("FAIL lat_bin edge %0d got %h want %h", e, sync_bin3, e >= 4);
            end
            n_cmp++;
            if (ptr_upd3 !== (e == 4)) begin
                n_err++; $display("FAIL lat_upd edge %0d got %b want %b", e, ptr_upd3, e == 4);
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp;
        logic [W-1:0] code;
        gray_in = 7'h00;
        for (int e = 0; e < 6; e++) step();
        n_cmp++;
        if (sync_bin2 !== 7'h00) begin n_err++; $display("FAIL wrap_start got %h want 00", sync_bin2); end
        exp_q.delete();
        for (int i = 1; i <= 134; i++) begin
            if (i <= 128) begin
                code = W'(i);
                gray_in = bin2gray(code);
                exp_q.push_back(code);
            end
            for (int c = 0; c < 2; c++) begin
                step();
                if (ptr_upd2) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL wrap_extra_upd got %h want none", sync_bin2);
                    end else begin
                        exp = exp_q.pop_front();
                        if (sync_bin2 !== exp) begin
                            n_err++; $display("FAIL wrap_bin got %h want %h", sync_bin2, exp);
                        end
                    end
                end
            end
        end
        n_cmp += 3;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL wrap_missing got %0d left want 0", exp_q.size());
        end
        if (gray_err2 !== 1'b0) begin n_err++; $display("FAIL wrap_err2 got %b want 0", gray_err2); end
        if (gray_err3 !== 1'b0) begin n_err++; $display("FAIL wrap_err3 got %b want 0", gray_err3); end
    endtask

    task automatic test_error();
        gray_in = 7'h03;
        step(); step();
        n_cmp++;
        if (gray_err2 !== 1'b0) begin n_err++; $display("FAIL err_early got %b want 0", gray_err2); end
        step();
        n_cmp += 2;
        if (gray_err2 !== 1'b1) begin n_err++; $display("FAIL err_set2 got %b want 1", gray_err2); end
        if (gray_err3 !== 1'b0) begin n_err++; $display("FAIL err_early3 got %b want 0", gray_err3); end
        step();
        n_cmp++;
        if (gray_err3 !== 1'b1) begin n_err++; $display("FAIL err_set3 got %b want 1", gray_err3); end
        step(); step();
        n_cmp++;
        if (gray_err2 !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", gray_err2); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp += 2;
        if (gray_err2 !== 1'b0) begin n_err++; $display("FAIL err_clr2 got %b want 0", gray_err2); end
        if (gray_err3 !== 1'b0) begin n_err++; $display("FAIL err_clr3 got %b want 0", gray_err3); end
    endtask

    task automatic test_set_wins();
        gray_in = 7'h00;
        step(); step();
        err_clr = 1'b1;
        step();
        n_cmp++;
        if (gray_err2 !== 1'b1) begin n_err++; $display("FAIL setwins2 got %b want 1", gray_err2); end
        step();
        err_clr = 1'b0;
        n_cmp += 2;
        if (gray_err3 !== 1'b1) begin n_err++; $display("FAIL setwins3 got %b want 1", gray_err3); end
        if (gray_err2 !== 1'b0) begin n_err++; $display("FAIL clr_after_set got %b want 0", gray_err2); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_midop_reset();
        int pulses;
        gray_in = 7'h01;
        step(); step();
        n_cmp += 2;
        if (sync_gray2 !== 7'h01) begin n_err++; $display("FAIL mid_inflight got %h want 01", sync_gray2); end
        if (sync_bin2 !== 7'h00)  begin n_err++; $display("FAIL mid_bin_pre got %h want 00", sync_bin2); end
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (sync_gray2 !== 7'h00) begin n_err++; $display("FAIL mid_rst_gray got %h want 00", sync_gray2); end
        if (sync_bin2 !== 7'h00)  begin n_err++; $display("FAIL mid_rst_bin got %h want 00", sync_bin2); end
        if (sync_vld2 !== 1'b0)   begin n_err++; $display("FAIL mid_rst_vld got %b want 0", sync_vld2); end
        if (ptr_upd2 !== 1'b0)    begin n_err++; $display("FAIL mid_rst_upd got %b want 0", ptr_upd2); end
        step(); step();
        rst = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (ptr_upd2) pulses++;
            if (e <= 3) begin
                n_cmp++;
                if (sync_vld2 !== (e == 3)) begin
                    n_err++; $display("FAIL mid_warmup edge %0d got %b want %b", e, sync_vld2, e == 3);
                end
            end
        end
        n_cmp += 2;
        if (sync_bin2 !== 7'h01) begin n_err++; $display("FAIL mid_bin_post got %h want 01", sync_bin2); end
        if (pulses != 0) begin n_err++; $display("FAIL mid_no_upd got %0d pulses want 0", pulses); end
    endtask

    initial begin
        rst = 1'b1;
        gray_in = '0;
        err_clr = 1'b0;
        test_reset();
        test_latency();
        test_wrap();
        test_error();
        test_set_wins();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
